serial_adder: RTL



---
 rtl/serial_adder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one sum bit per clock, LSB first.
// Operands a, b and cin are taken through an in_valid/in_ready handshake.
// The WIDTH-bit sum and the carry-out are offered through out_valid/out_ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, cin            operands and carry-in
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   sum, cout            (a+b+cin) mod 2^WIDTH and bit WIDTH of a+b+cin
//   busy                 high while an operation is in flight (RUN or DONE)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;

  logic w_ha0_s;
  logic w_ha0_c;
  logic w_ha1_s;
  logic w_ha1_c;
  logic w_carry_nxt;
  logic w_accept;
  logic w_run;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DONE is entered on the same edge that consumes the MSB
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)           w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)          w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Two cascaded half adders form one full-adder bit slice
  assign w_ha0_s     = r_sa[0] ^ r_sb[0];
  assign w_ha0_c     = r_sa[0] & r_sb[0];
  assign w_ha1_s     = w_ha0_s ^ r_c;
  assign w_ha1_c     = w_ha0_s & r_c;
  assign w_carry_nxt = w_ha0_c | w_ha1_c;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_run    = (r_state == S_RUN);

  // Operand capture and serial datapath; sum bits enter at the MSB end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_ss  <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_c   <= cin;
      r_cnt <= '0;
    end else if (w_run) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_ss  <= {w_ha1_s, r_ss[WIDTH-1:1]};
      r_c   <= w_carry_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign sum  = r_ss;
  assign cout = r_c;

endmodule
